// File: rtl/spm_seq_if.sv
// Handshake/operand bundle for spm_seq. With SPM_SEQ_ACC_EN defined an
// accum request bit joins the master-driven group.
interface spm_seq_if #(
    parameter int XW = 32,
    parameter int YW = 32
);
    localparam int PW = XW + YW;

    logic          start;
    logic          sgn;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
`ifdef SPM_SEQ_ACC_EN
    logic          accum;
`endif
    logic          busy;
    logic          done;
    logic [PW-1:0] p;

    modport master (
`ifdef SPM_SEQ_ACC_EN
        output accum,
`endif
        output start, sgn, x, y,
        input  busy, done, p
    );

    modport slave (
`ifdef SPM_SEQ_ACC_EN
        input  accum,
`endif
        input  start, sgn, x, y,
        output busy, done, p
    );
endinterface

// File: rtl/spm_seq.sv
// Serial-parallel multiplier: y streams LSB-first against parallel x through a
// carry-save cell chain; PW+1 cycle latency. SPM_SEQ_ACC_EN adds p accumulation.
module spm_seq #(
    parameter  int XW = 32,
    parameter  int YW = 32,
    localparam int PW = XW + YW
) (
    input  logic     clk,
    input  logic     rst,
    spm_seq_if.slave bus
);
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          sgn_q, sgn_d;
    logic          yext_q, yext_d;
    logic [XW-2:0] s_q, s_d;
    logic [XW-1:0] c_q, c_d;
    logic [PW-2:0] col_q, col_d;
    logic [PW-1:0] p_q, p_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept_s;
`ifdef SPM_SEQ_ACC_EN
    logic          acc_q, acc_d;
`endif

    logic [XW-1:0] pp_s;
    logic [XW-1:0] ns_s;
    logic [XW-1:0] nc_s;

    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        fa = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Cell chain: positive-weight full adders, MSB cell adds (unsigned) or
    // subtracts (signed); in signed mode its carry flag is a borrow of weight -1.
    always_comb begin
        pp_s = x_q & {XW{y_q[0]}};
        ns_s = '0;
        nc_s = '0;
        for (int i = 0; i < XW - 1; i++) begin
            {nc_s[i], ns_s[i]} = fa(pp_s[i], s_q[i], c_q[i]);
        end
        ns_s[XW-1] = pp_s[XW-1] ^ c_q[XW-1];
        if (sgn_q) begin
            nc_s[XW-1] = pp_s[XW-1] | c_q[XW-1];
        end else begin
            nc_s[XW-1] = pp_s[XW-1] & c_q[XW-1];
        end
    end

    // FSM next state, serial datapath advance and product update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        sgn_d    = sgn_q;
        yext_d   = yext_q;
        s_d      = s_q;
        c_d      = c_q;
        col_d    = col_q;
        p_d      = p_q;
`ifdef SPM_SEQ_ACC_EN
        acc_d    = acc_q;
`endif
        accept_s = bus.start & (state_q != S_RUN);

        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            S_RUN: begin
                s_d   = ns_s[XW-1:1];
                c_d   = nc_s;
                y_d   = {yext_q, y_q[YW-1:1]};
                col_d = {ns_s[0], col_q[PW-2:1]};
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
`ifdef SPM_SEQ_ACC_EN
                    if (acc_q) p_d = p_q + {ns_s[0], col_q};
                    else       p_d = {ns_s[0], col_q};
`else
                    p_d = {ns_s[0], col_q};
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (accept_s) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operands are captured only on accept; start during RUN never gets here.
        if (accept_s) begin
            cnt_d  = CW'(PW - 1);
            x_d    = bus.x;
            y_d    = bus.y;
            sgn_d  = bus.sgn;
            yext_d = bus.sgn & bus.y[YW-1];
            s_d    = '0;
            c_d    = '0;
            col_d  = '0;
`ifdef SPM_SEQ_ACC_EN
            acc_d  = bus.accum;
`endif
        end else begin
            sgn_d  = sgn_q;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            yext_q  <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            col_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPM_SEQ_ACC_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            yext_q  <= yext_d;
            s_q     <= s_d;
            c_q     <= c_d;
            col_q   <= col_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPM_SEQ_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
endmodule

// File: tb/tb_spm_seq.sv
// Self-checking bench for spm_seq: vector table plus handshake/reset corner
// sequences; products are checked by a scoreboard on each done pulse.
module tb_spm_seq;
    localparam int XW = 32;
    localparam int YW = 32;
    localparam int PW = 64;

    typedef struct {
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp_p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spm_seq_if #(.XW(XW), .YW(YW)) ifc ();
    spm_seq #(.XW(XW), .YW(YW)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'd0, a};
        be = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ae * be;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst == 1'b0 && ifc.done === 1'b1) begin
            check("busy_during_done", {63'd0, ifc.busy}, 64'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done pulse, expected none (p=0x%016h)", ifc.p);
            end else begin
                mon_exp = sb.pop_front();
                check("product", ifc.p, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one sample after accept (cycle lat0); returns the cycle done is seen.
    task automatic wait_done(input int lat0, output int lat, output int nb);
        lat = lat0;
        nb  = 0;
        while (ifc.done !== 1'b1 && lat < 200) begin
            if (ifc.busy === 1'b1) nb++;
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input string name);
        int lat, nb;
        ifc.start = 1'b1;
        ifc.sgn   = s;
        ifc.x     = a;
        ifc.y     = b;
        tick();
        ifc.start = 1'b0;
        sb.push_back(e);
        wait_done(1, lat, nb);
        check({name, "_latency"}, 64'(lat), 64'd65);
        check({name, "_busy_cycles"}, 64'(nb), 64'd64);
    endtask

    initial begin
        vec_t tbl[10];
        int   lat, nb;
        logic rs;
        logic [31:0] ra, rb;

        tbl[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[4] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[5] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        tbl[7] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        tbl[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[9] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};

        ifc.start = 1'b0;
        ifc.sgn   = 1'b0;
        ifc.x     = 32'd0;
        ifc.y     = 32'd0;
`ifdef SPM_SEQ_ACC_EN
        ifc.accum = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) tick();
        check("reset_busy", {63'd0, ifc.busy}, 64'd0);
        check("reset_done", {63'd0, ifc.done}, 64'd0);
        check("reset_p", ifc.p, 64'd0);
        rst = 1'b0;
        tick();

        // First multiply, then confirm the done pulse is a single cycle.
        do_op(1'b0, 32'd3, 32'd5, 64'd15, "first_op");
        tick();
        check("done_one_cycle", {63'd0, ifc.done}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].sgn, tbl[i].x, tbl[i].y, tbl[i].exp_p, $sformatf("vec%0d", i));
            tick();
        end

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            do_op(rs, ra, rb, ref_mul(rs, ra, rb), $sformatf("rand%0d", i));
        end
        tick();

        // start pulsed during RUN cycle 10 is ignored; p holds the old value.
        do_op(1'b0, 32'd100, 32'd200, 64'd20000, "pre_hold");
        tick();
        ifc.start = 1'b1;
        ifc.sgn   = 1'b0;
        ifc.x     = 32'd11;
        ifc.y     = 32'd13;
        tick();
        ifc.start = 1'b0;
        sb.push_back(64'd143);
        repeat (9) tick();
        ifc.start = 1'b1;
        ifc.x     = 32'd9;
        tick();
        ifc.start = 1'b0;
        repeat (9) tick();
        check("p_hold_in_run", ifc.p, 64'd20000);
        wait_done(20, lat, nb);
        check("ignored_start_latency", 64'(lat), 64'd65);
        tick();

        // start held through DONE gives a back-to-back accept.
        ifc.start = 1'b1;
        ifc.x     = 32'd5;
        ifc.y     = 32'd6;
        tick();
        sb.push_back(64'd30);
        ifc.x     = 32'd8;
        ifc.y     = 32'd9;
        wait_done(1, lat, nb);
        check("b2b_first_latency", 64'(lat), 64'd65);
        sb.push_back(64'd72);
        tick();
        ifc.start = 1'b0;
        wait_done(1, lat, nb);
        check("b2b_second_latency", 64'(lat), 64'd65);
        tick();

        // Reset in RUN cycle 30 aborts without a done pulse.
        ifc.start = 1'b1;
        ifc.x     = 32'd3;
        ifc.y     = 32'd5;
        tick();
        ifc.start = 1'b0;
        repeat (29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {63'd0, ifc.busy}, 64'd0);
        check("midrst_done", {63'd0, ifc.done}, 64'd0);
        check("midrst_p", ifc.p, 64'd0);
        repeat (80) tick();
        do_op(1'b0, 32'd7, 32'd6, 64'd42, "after_rst");
        tick();

`ifdef SPM_SEQ_ACC_EN
        ifc.accum = 1'b0;
        do_op(1'b0, 32'd4, 32'd5, 64'd20, "acc_load");
        tick();
        ifc.accum = 1'b1;
        do_op(1'b0, 32'd2, 32'd3, 64'd26, "acc_add");
        tick();
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 64'd25, "acc_signed");
        tick();
        ifc.accum = 1'b0;
`endif

        repeat (5) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
